// File: rtl/output_accum_writeback_pkg.sv
// rtl/output_accum_writeback_pkg.sv - shared types and Q-format arithmetic for the accumulator writeback block
package output_accum_writeback_pkg;

    localparam int PKG_DATA_WIDTH = 32;
    localparam int PKG_FRAC_WIDTH = 16;

    typedef logic signed [PKG_DATA_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_CLIP  = 2'd3
    } act_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } clr_state_t;

    typedef struct packed {
        logic  ovf;
        word_t value;
    } sat_sum_t;

    function automatic sat_sum_t sat_add(input word_t a, input word_t b);
        logic signed [PKG_DATA_WIDTH:0] wide;
        sat_sum_t r;
        wide  = {a[PKG_DATA_WIDTH-1], a} + {b[PKG_DATA_WIDTH-1], b};
        r.ovf = wide[PKG_DATA_WIDTH] != wide[PKG_DATA_WIDTH-1];
        if (!r.ovf)
            r.value = wide[PKG_DATA_WIDTH-1:0];
        else if (wide[PKG_DATA_WIDTH])
            r.value = {1'b1, {(PKG_DATA_WIDTH-1){1'b0}}};
        else
            r.value = {1'b0, {(PKG_DATA_WIDTH-1){1'b1}}};
        return r;
    endfunction

    function automatic word_t activate(input word_t s, input act_mode_t mode,
                                       input int leaky_shift, input word_t clip);
        word_t r;
        r = s;
        case (mode)
            ACT_RELU:  if (s[PKG_DATA_WIDTH-1]) r = '0;
            ACT_LEAKY: if (s[PKG_DATA_WIDTH-1]) r = s >>> leaky_shift;
            ACT_CLIP: begin
                if (s[PKG_DATA_WIDTH-1]) r = '0;
                else if (s > clip)       r = clip;
            end
            default:   r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/output_lane_ram.sv
// rtl/output_lane_ram.sv - simple dual-port lane RAM, registered read-first read port
module output_lane_ram #(
    parameter int DEPTH      = 1152,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_wr_en)
            mem[i_wr_addr] <= i_wr_data;
    end

    // Same-edge write is not visible here: the read returns the old word.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            o_rd_data <= '0;
        else if (i_rd_en)
            o_rd_data <= mem[i_rd_addr];
    end

endmodule

// File: rtl/output_accum_writeback.sv
// rtl/output_accum_writeback.sv - per-lane saturating accumulator with activation and result buffer
module output_accum_writeback
    import output_accum_writeback_pkg::*;
#(
    parameter int DATA_WIDTH  = PKG_DATA_WIDTH,
    parameter int FRAC_WIDTH  = PKG_FRAC_WIDTH,
    parameter int LANES       = 4,
    parameter int DEPTH       = 1152,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int LEAKY_SHIFT = 3,
    parameter int CLIP_VALUE  = 6 << FRAC_WIDTH
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [LANES*ADDR_WIDTH-1:0]   i_addr,
    input  logic [LANES*DATA_WIDTH-1:0]   i_conv_result,
    input  logic [LANES*DATA_WIDTH-1:0]   i_bias,
    input  logic                          i_first,
    input  logic                          i_last,
    input  logic [1:0]                    i_act_mode,
    input  logic                          i_clear,
    output logic                          o_busy,
    output logic [LANES-1:0]              o_overflow,
    input  logic                          i_rd_en,
    input  logic [LANES*ADDR_WIDTH-1:0]   i_rd_addr,
    output logic [LANES*DATA_WIDTH-1:0]   o_rd_data,
    output logic                          o_rd_valid
);

    localparam word_t CLIP_W = word_t'(CLIP_VALUE);

    clr_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q;
    logic                    out_of_reset_q;
    logic                    accept, clearing;
    logic                    s1_valid, s2_valid, wb_valid;
    logic                    s1_first, s1_last, s2_last;
    act_mode_t               s1_mode, s2_mode;
    logic [LANES-1:0]        lane_ovf;

    assign o_ready  = out_of_reset_q && (state_q == IDLE);
    assign o_busy   = (state_q != IDLE);
    assign accept   = i_valid && o_ready;
    assign clearing = (state_q == CLEAR);

    // DRAIN leaves as soon as S1 is empty: the S2 beat commits on that same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_clear)   state_d = DRAIN;
            DRAIN:   if (!s1_valid) state_d = CLEAR;
            CLEAR:   if (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q        <= IDLE;
            clr_addr_q     <= '0;
            out_of_reset_q <= 1'b0;
            s1_valid       <= 1'b0;
            s2_valid       <= 1'b0;
            wb_valid       <= 1'b0;
            o_rd_valid     <= 1'b0;
            o_overflow     <= '0;
        end else begin
            state_q        <= state_d;
            clr_addr_q     <= clearing ? clr_addr_q + 1'b1 : '0;
            out_of_reset_q <= 1'b1;
            s1_valid       <= accept;
            s2_valid       <= s1_valid;
            wb_valid       <= s2_valid;
            o_rd_valid     <= i_rd_en;
            if (state_q == DRAIN && state_d == CLEAR)
                o_overflow <= '0;
            else
                o_overflow <= o_overflow | lane_ovf;
        end
    end

    always_ff @(posedge i_clock) begin
        if (accept) begin
            s1_first <= i_first;
            s1_last  <= i_last;
            s1_mode  <= act_mode_t'(i_act_mode);
        end
        if (s1_valid) begin
            s2_last <= s1_last;
            s2_mode <= s1_mode;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [ADDR_WIDTH-1:0] s1_addr, s2_addr, wb_addr, wr_addr;
        word_t                 s1_conv, s1_bias, s2_sum, wb_sum;
        word_t                 part_q, operand, act, part_wdata, res_wdata;
        sat_sum_t              sum;

        // S2 has not written yet; the WB beat wrote on the same edge the RAM was read.
        always_comb begin
            if (s1_first)
                operand = s1_bias;
            else if (s2_valid && s2_addr == s1_addr)
                operand = s2_sum;
            else if (wb_valid && wb_addr == s1_addr)
                operand = wb_sum;
            else
                operand = part_q;
        end

        assign sum         = sat_add(operand, s1_conv);
        assign lane_ovf[l] = s1_valid && sum.ovf;
        assign act         = activate(s2_sum, s2_mode, LEAKY_SHIFT, CLIP_W);
        assign wr_addr     = clearing ? clr_addr_q : s2_addr;
        assign part_wdata  = clearing ? '0 : s2_sum;
        assign res_wdata   = clearing ? '0 : act;

        always_ff @(posedge i_clock) begin
            if (accept) begin
                s1_addr <= i_addr[l*ADDR_WIDTH +: ADDR_WIDTH];
                s1_conv <= i_conv_result[l*DATA_WIDTH +: DATA_WIDTH];
                s1_bias <= i_bias[l*DATA_WIDTH +: DATA_WIDTH];
            end
            if (s1_valid) begin
                s2_addr <= s1_addr;
                s2_sum  <= sum.value;
            end
            if (s2_valid) begin
                wb_addr <= s2_addr;
                wb_sum  <= s2_sum;
            end
        end

        output_lane_ram #(
            .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
        ) u_part_ram (
            .i_clock   (i_clock),
            .i_reset   (i_reset),
            .i_wr_en   (s2_valid || clearing),
            .i_wr_addr (wr_addr),
            .i_wr_data (part_wdata),
            .i_rd_en   (accept),
            .i_rd_addr (i_addr[l*ADDR_WIDTH +: ADDR_WIDTH]),
            .o_rd_data (part_q)
        );

        output_lane_ram #(
            .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
        ) u_result_ram (
            .i_clock   (i_clock),
            .i_reset   (i_reset),
            .i_wr_en   ((s2_valid && s2_last) || clearing),
            .i_wr_addr (wr_addr),
            .i_wr_data (res_wdata),
            .i_rd_en   (i_rd_en),
            .i_rd_addr (i_rd_addr[l*ADDR_WIDTH +: ADDR_WIDTH]),
            .o_rd_data (o_rd_data[l*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_output_accum_writeback.sv
// tb/tb_output_accum_writeback.sv - directed self-checking bench for output_accum_writeback
module tb_output_accum_writeback;

    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1152;
    localparam int AW    = $clog2(DEPTH);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  valid, ready, first, last, clear, busy, rd_en, rd_valid;
    logic [1:0]            mode;
    logic [LANES*AW-1:0]   addr, rd_addr;
    logic [LANES*DW-1:0]   conv, bias, rd_data;
    logic [LANES-1:0]      ovf;

    logic [AW-1:0]         la [LANES];
    logic [DW-1:0]         lc [LANES];
    logic [DW-1:0]         lb [LANES];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    output_accum_writeback dut (
        .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .o_ready(ready),
        .i_addr(addr), .i_conv_result(conv), .i_bias(bias),
        .i_first(first), .i_last(last), .i_act_mode(mode),
        .i_clear(clear), .o_busy(busy), .o_overflow(ovf),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LANES*AW-1:0] pack_addr(input int a);
        logic [LANES*AW-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*AW +: AW] = AW'(a);
        return r;
    endfunction

    task automatic set_all(input int a, input logic [DW-1:0] c, input logic [DW-1:0] b);
        for (int l = 0; l < LANES; l++) begin
            la[l] = AW'(a);
            lc[l] = c;
            lb[l] = b;
        end
    endtask

    task automatic send(input logic f, input logic lst, input logic [1:0] m);
        for (int l = 0; l < LANES; l++) begin
            addr[l*AW +: AW] = la[l];
            conv[l*DW +: DW] = lc[l];
            bias[l*DW +: DW] = lb[l];
        end
        valid = 1'b1; first = f; last = lst; mode = m;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic rd(input int a);
        rd_addr = pack_addr(a);
        rd_en   = 1'b1;
        @(posedge clk); #1;
        rd_en   = 1'b0;
    endtask

    task automatic check_lanes(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                               input logic [DW-1:0] e2, input logic [DW-1:0] e3);
        logic [DW-1:0] e [LANES];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int l = 0; l < LANES; l++)
            check($sformatf("%s[%0d]", tag, l), 64'(rd_data[l*DW +: DW]), 64'(e[l]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

    initial begin
        int cnt, nz;
        logic busy_all;
        logic [DW-1:0] r60, r61;

        rst_n = 1'b0; valid = 1'b0; first = 1'b0; last = 1'b0; mode = 2'd0;
        clear = 1'b0; rd_en = 1'b0; addr = '0; rd_addr = '0; conv = '0; bias = '0;
        #12;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data == '0), 64'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 64'(ready), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);

        // seed with bias, then accumulate on the next cycle (S2 forwarding)
        set_all(5, 32'h0002_0000, 32'h0001_0000);
        send(1'b1, 1'b0, 2'd0);
        for (int l = 0; l < LANES; l++) lc[l] = 32'h0000_8000 * (l + 1);
        send(1'b0, 1'b1, 2'd0);
        idle(2);
        rd(5);
        check("seed_rd_valid", 64'(rd_valid), 64'd1);
        check_lanes("seed_acc", 32'h0003_8000, 32'h0004_0000, 32'h0004_8000, 32'h0005_0000);
        idle(1);
        check("rd_valid_drop", 64'(rd_valid), 64'd0);

        // activation modes
        set_all(20, 32'hFFFE_0000, 32'h0); lc[3] = 32'h0001_0000; send(1'b1, 1'b1, 2'd0);
        set_all(21, 32'hFFFE_0000, 32'h0); lc[3] = 32'h0001_0000; send(1'b1, 1'b1, 2'd1);
        set_all(22, 32'hFFFE_0000, 32'h0); lc[3] = 32'h0001_0000; send(1'b1, 1'b1, 2'd2);
        set_all(23, 32'h0, 32'h0);
        lc[0] = 32'h0007_0000; lc[1] = 32'h0002_0000; lc[2] = 32'hFFFE_0000; lc[3] = 32'h0006_0000;
        send(1'b1, 1'b1, 2'd3);
        idle(2);
        rd(20); check_lanes("act_none", 32'hFFFE_0000, 32'hFFFE_0000, 32'hFFFE_0000, 32'h0001_0000);
        rd(21); check_lanes("act_relu", 32'h0, 32'h0, 32'h0, 32'h0001_0000);
        rd(22); check_lanes("act_leaky", 32'hFFFF_C000, 32'hFFFF_C000, 32'hFFFF_C000, 32'h0001_0000);
        rd(23); check_lanes("act_clip", 32'h0006_0000, 32'h0002_0000, 32'h0, 32'h0006_0000);

        // positive saturation on lane 2, negative on lane 3
        set_all(30, 32'h0, 32'h0001_0000); lb[2] = 32'h7FFF_0000; lb[3] = 32'h8001_0000;
        send(1'b1, 1'b0, 2'd0);
        set_all(30, 32'h0002_0000, 32'h0); lc[3] = 32'hFFFE_0000;
        send(1'b0, 1'b1, 2'd0);
        idle(2);
        rd(30); check_lanes("sat", 32'h0003_0000, 32'h0003_0000, 32'h7FFF_FFFF, 32'h8000_0000);
        check("sat_ovf", 64'(ovf), 64'hC);

        // read-first and read latency
        set_all(50, 32'h0001_0000, 32'h0); send(1'b1, 1'b1, 2'd0); idle(2);
        rd(50); check_lanes("rf_init", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        set_all(50, 32'h0002_0000, 32'h0); send(1'b1, 1'b1, 2'd0); idle(1);
        rd(50); check_lanes("rf_old", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        rd(50); check_lanes("rf_new", 32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000);

        // gap hazard: beats to addr 9 at cycles 0 and 2, mixed addresses at cycle 1
        set_all(3, 32'h0, 32'h0005_0000); send(1'b1, 1'b1, 2'd0); idle(2);
        set_all(9, 32'h0001_0000, 32'h0001_0000); send(1'b1, 1'b0, 2'd0);
        set_all(9, 32'h0001_0000, 32'h0); la[1] = AW'(3); la[3] = AW'(3); send(1'b0, 1'b1, 2'd0);
        set_all(9, 32'h0000_8000, 32'h0); send(1'b0, 1'b1, 2'd0);
        idle(2);
        rd(9); check_lanes("gap_a9", 32'h0003_8000, 32'h0002_8000, 32'h0003_8000, 32'h0002_8000);
        rd(3); check_lanes("gap_a3", 32'h0005_0000, 32'h0006_0000, 32'h0005_0000, 32'h0006_0000);

        // back-to-back stream to one address
        set_all(40, 32'h0, 32'h0001_0000); send(1'b1, 1'b0, 2'd0);
        set_all(40, 32'h0001_0000, 32'h0);
        send(1'b0, 1'b0, 2'd0); send(1'b0, 1'b0, 2'd0); send(1'b0, 1'b1, 2'd0);
        idle(2);
        rd(40); check_lanes("stream", 32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000);
        check("ovf_sticky", 64'(ovf), 64'hC);

        // clear with two beats in flight
        set_all(60, 32'h0001_0000, 32'h0); send(1'b1, 1'b1, 2'd0);
        set_all(61, 32'h0002_0000, 32'h0); clear = 1'b1; send(1'b1, 1'b1, 2'd0); clear = 1'b0;
        cnt = 0; busy_all = 1'b1; r60 = '0; r61 = '0;
        while (ready !== 1'b1 && cnt < 3000) begin
            busy_all = busy_all & busy;
            rd_en    = (cnt == 4) || (cnt == 5);
            rd_addr  = pack_addr(cnt == 4 ? 60 : 61);
            clear    = (cnt == 500);
            @(posedge clk); #1;
            cnt++;
            if (cnt == 5) r60 = rd_data[DW-1:0];
            if (cnt == 6) r61 = rd_data[DW-1:0];
        end
        rd_en = 1'b0; clear = 1'b0;
        check("clr_ready_low_cycles_in_range", 64'(cnt >= DEPTH && cnt <= DEPTH + 2), 64'd1);
        check("clr_busy_held", 64'(busy_all), 64'd1);
        check("clr_beat1_commit", 64'(r60), 64'h0001_0000);
        check("clr_beat2_commit", 64'(r61), 64'h0002_0000);
        check("clr_ovf", 64'(ovf), 64'd0);
        check("clr_busy_done", 64'(busy), 64'd0);
        nz = 0;
        for (int a = 0; a < DEPTH; a++) begin
            rd(a);
            if (rd_data !== '0) nz++;
        end
        check("clr_nonzero_words", 64'(nz), 64'd0);

        // async reset in the middle of a clear
        set_all(70, 32'h7FFF_FFFF, 32'h0); send(1'b1, 1'b1, 2'd0); idle(2);
        clear = 1'b1; idle(1); clear = 1'b0;
        idle(8);
        rd_addr = pack_addr(70); rd_en = 1'b1;
        @(posedge clk); #1;
        check("mid_clr_busy", 64'(busy), 64'd1);
        check("mid_clr_rd", 64'(rd_data[DW-1:0]), 64'h7FFF_FFFF);
        check("mid_clr_rd_valid", 64'(rd_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_ready", 64'(ready), 64'd0);
        check("areset_busy", 64'(busy), 64'd0);
        check("areset_ovf", 64'(ovf), 64'd0);
        check("areset_rd_valid", 64'(rd_valid), 64'd0);
        check("areset_rd_data", 64'(rd_data == '0), 64'd1);
        rd_en = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rerel_ready", 64'(ready), 64'd1);
        check("rerel_busy", 64'(busy), 64'd0);
        set_all(80, 32'h0003_0000, 32'h0); send(1'b1, 1'b1, 2'd0); idle(2);
        rd(80); check_lanes("post_rst_beat", 32'h0003_0000, 32'h0003_0000, 32'h0003_0000, 32'h0003_0000);
        rd(70); check_lanes("clr_aborted", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
